serial_subtractor: RTL

- Parametrised, bit-serial successor to the team's single-bit subtractor.
- Computes Diff = A - B - Bin over WIDTH-bit unsigned operands, one bit per clock, LSB first, using one full-subtractor cell and a borrow flop.
- Reports borrow-out and a zero flag through a start/busy/done handshake.
- Used where area matters more than latency, e.g. counters and comparators in the small datapath blocks.

---
 rtl/serial_subtractor.sv | 129 ++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), processed LSB
//   first, one bit per clock, with a single full-subtractor cell and a
//   borrow flop. Handshake: start (accepted when not busy), busy while bits
//   are processed, one-cycle done pulse when the result is valid.
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   asynchronous active-high reset
//   start  in   operation request, sampled only while busy=0
//   a      in   minuend    (WIDTH), latched on the accepting edge
//   b      in   subtrahend (WIDTH), latched on the accepting edge
//   bin    in   borrow-in, latched on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, result valid
//   diff   out  result (WIDTH), held until the next completion
//   borrow out  final borrow-out (1 when a < b + bin)
//   zero   out  high when diff == 0
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, b_reg, work_reg;
  logic [WIDTH-1:0] work_shift;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;
  logic             d_bit, br_bit, last_bit, accept;

  // Full-subtractor cell on the current LSBs of the operand shift registers.
  assign d_bit    = a_reg[0] ^ b_reg[0] ^ br_reg;
  assign br_bit   = (~a_reg[0] & b_reg[0]) | (~(a_reg[0] ^ b_reg[0]) & br_reg);
  assign last_bit = (cnt_reg == CW'(WIDTH - 1));

  // New result bit enters at the MSB so that after WIDTH shifts bit 0 sits
  // at position 0. A one-bit result has nothing to shift.
  generate
    if (WIDTH == 1) begin : g_w1
      assign work_shift = d_bit;
    end else begin : g_wn
      assign work_shift = {d_bit, work_reg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        // A request here starts the next operation without an IDLE cycle.
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      work_reg  <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      diff      <= '0;
      borrow    <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        a_reg   <= a;
        b_reg   <= b;
        br_reg  <= bin;
        cnt_reg <= '0;
      end else if (state_reg == RUN) begin
        a_reg    <= a_reg >> 1;
        b_reg    <= b_reg >> 1;
        br_reg   <= br_bit;
        cnt_reg  <= cnt_reg + CW'(1);
        work_reg <= work_shift;
        // Published outputs only change on the final bit; they hold otherwise.
        if (last_bit) begin
          diff   <= work_shift;
          borrow <= br_bit;
          zero   <= (work_shift == '0);
        end
      end
    end
  end

endmodule
